uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter giving four byte requesters turns on one UART
// transmitter. Each grant launches one byte (Tx_en strobe + ack), waits for the
// transmitter to go busy and then idle again, and reports completion with done.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a launch that the transmitter
// never acknowledges (Tx_busy stays low) after TIMEOUT_CYCLES cycles, flagged on err.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [7:0]  data_in,
    output logic        Tx_en,
    input  logic        Tx_busy,
    output logic [1:0]  gnt_id,
    output logic        arb_busy,
    output logic        err
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWaitBusy = 2'd2,
        StWaitDone = 2'd3
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] r_gnt;
    logic [7:0] r_data;
    logic [1:0] w_sel;
    logic       w_grant;
    logic       w_timeout;

    // Grant only from IDLE with an idle transmitter; external busy keeps requests pending.
    assign w_grant = (r_state == StIdle) && (|req) && !Tx_busy;

    // Round-robin pick: first set req bit at or above r_ptr, wrapping 3->0.
    // Scanning offsets from high to low lets the smallest offset win.
    always_comb begin
        w_sel = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_sel = r_ptr + 2'(k);
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_cnt;

    // Abort once TIMEOUT_CYCLES full cycles in WAIT_BUSY passed without Tx_busy.
    assign w_timeout = (r_state == StWaitBusy) && !Tx_busy &&
                       (r_cnt == CntW'(TIMEOUT_CYCLES));

    // Cycle counter for WAIT_BUSY; cleared in every other state.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == StWaitBusy) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // State register.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: pointer, owner id and captured byte change only on a grant.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 2'd0;
            r_gnt  <= 2'd0;
            r_data <= 8'h00;
        end else if (w_grant) begin
            r_ptr  <= w_sel + 2'd1;
            r_gnt  <= w_sel;
            r_data <= req_data[{w_sel, 3'b000} +: 8];
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        Tx_en       = 1'b0;
        ack         = 4'b0000;
        done        = 4'b0000;
        unique case (r_state)
            StIdle: begin
                if (w_grant) begin
                    w_state_nxt = StLaunch;
                end
            end
            StLaunch: begin
                Tx_en       = 1'b1;
                ack         = 4'b0001 << r_gnt;
                w_state_nxt = StWaitBusy;
            end
            StWaitBusy: begin
                if (Tx_busy) begin
                    w_state_nxt = StWaitDone;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                end
            end
            StWaitDone: begin
                if (!Tx_busy) begin
                    done        = 4'b0001 << r_gnt;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign data_in  = r_data;
    assign gnt_id   = r_gnt;
    assign arb_busy = (r_state != StIdle);
    assign err      = w_timeout;

endmodule
